// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg -- shared types and constants for the Game Boy cartridge bus target.
// Rev 1.0
`default_nettype none

package gb_bus_pkg;

  localparam int GB_ADDR_W = 16;
  localparam int GB_DATA_W = 8;

  localparam logic        GB_ROM_A15  = 1'b0;
  localparam logic [15:0] GB_RAM_BASE = 16'hA000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RD_REQ    = 2'd1,
    ST_RD_DRIVE  = 2'd2,
    ST_WR_ACTIVE = 2'd3
  } gb_bus_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// sync_ff -- generic multi-flop synchroniser with async active-low reset.
// Rev 1.0
`default_nettype none

module sync_ff #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gb_bus_target.sv
// gb_bus_target -- cartridge-side Game Boy bus target: strobe sync, cycle qualification, backend handshake.
// Rev 1.0
`default_nettype none

module gb_bus_target
  import gb_bus_pkg::*;
#(
  parameter int ADDR_W      = GB_ADDR_W,
  parameter int DATA_W      = GB_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] gb_addr,
  input  logic              gb_nrd,
  input  logic              gb_nwr,
  input  logic              gb_ncs,
  input  logic [DATA_W-1:0] pad_din,
  output logic [DATA_W-1:0] pad_dout,
  output logic [DATA_W-1:0] pad_oe,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ram,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ram,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [ADDR_W-1:0] addr_s, addr_p_q;
  logic [2:0]        strb_s, strb_p_q;
  logic [DATA_W-1:0] din_s;
  logic              nrd_s, nwr_s, ncs_s;
  logic              addr_chg, any_chg, in_range;
  logic [3:0]        cnt_q;
  logic              wr_ok_q;
  gb_bus_state_t     state_q;

  sync_ff #(.WIDTH(ADDR_W), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sync_addr (
    .clk(clk), .rst_n(rst_n), .d_i(gb_addr), .q_o(addr_s)
  );

  sync_ff #(.WIDTH(3), .STAGES(SYNC_STAGES), .RESET_VAL(3'b111)) u_sync_strb (
    .clk(clk), .rst_n(rst_n), .d_i({gb_ncs, gb_nwr, gb_nrd}), .q_o(strb_s)
  );

  // The pad already registers once, so the data path needs one stage fewer.
  sync_ff #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES-1), .RESET_VAL('0)) u_align_din (
    .clk(clk), .rst_n(rst_n), .d_i(pad_din), .q_o(din_s)
  );

  assign {ncs_s, nwr_s, nrd_s} = strb_s;
  assign addr_chg = (addr_s != addr_p_q);
  assign any_chg  = addr_chg || (strb_s != strb_p_q);
  assign in_range = (addr_s[ADDR_W-1] == GB_ROM_A15) || !ncs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p_q <= '0;
      strb_p_q <= 3'b111;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      pad_dout <= '0;
      pad_oe   <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      rd_ram   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_ram   <= 1'b0;
      wr_data  <= '0;
      wr_ok_q  <= 1'b0;
    end else begin
      addr_p_q <= addr_s;
      strb_p_q <= strb_s;
      if (any_chg)               cnt_q <= '0;
      else if (cnt_q != SETTLE_C) cnt_q <= cnt_q + 4'd1;
      wr_valid <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!nwr_s) begin
            state_q <= ST_WR_ACTIVE;
            wr_addr <= addr_s;
            wr_ram  <= !ncs_s;
            wr_data <= din_s;
            wr_ok_q <= in_range;
          end else if (!nrd_s && in_range && !any_chg && cnt_q == SETTLE_C) begin
            state_q <= ST_RD_REQ;
            rd_req  <= 1'b1;
            rd_addr <= addr_s;
            rd_ram  <= !ncs_s;
          end
        end
        ST_RD_REQ: begin
          // Abort wins over a coincident ack: the console has moved on.
          if (addr_chg || nrd_s || !nwr_s) begin
            state_q <= ST_IDLE;
            rd_req  <= 1'b0;
          end else if (rd_ack) begin
            state_q  <= ST_RD_DRIVE;
            rd_req   <= 1'b0;
            pad_dout <= rd_data;
            pad_oe   <= '1;
          end
        end
        ST_RD_DRIVE: begin
          if (addr_chg || nrd_s || !nwr_s || !in_range) begin
            state_q <= ST_IDLE;
            pad_oe  <= '0;
          end
        end
        ST_WR_ACTIVE: begin
          if (nwr_s) begin
            state_q  <= ST_IDLE;
            wr_valid <= wr_ok_q;
          end else begin
            wr_addr <= addr_s;
            wr_ram  <= !ncs_s;
            wr_data <= din_s;
            wr_ok_q <= in_range;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gb_bus_target.sv
// tb_gb_bus_target -- directed scoreboard bench for gb_bus_target.
// Rev 1.0
`default_nettype none

module tb_gb_bus_target;

  localparam int SYNC_STAGES = 2;
  localparam int SETTLE      = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gb_addr;
  logic        gb_nrd, gb_nwr, gb_ncs;
  logic [7:0]  pad_din, pad_dout, pad_oe;
  logic        rd_req, rd_ram, rd_ack;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  rd_data, wr_data;
  logic        wr_valid, wr_ram;

  gb_bus_target #(.ADDR_W(16), .DATA_W(8), .SYNC_STAGES(SYNC_STAGES), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .gb_addr(gb_addr), .gb_nrd(gb_nrd), .gb_nwr(gb_nwr),
    .gb_ncs(gb_ncs), .pad_din(pad_din), .pad_dout(pad_dout), .pad_oe(pad_oe),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ram(rd_ram), .rd_ack(rd_ack),
    .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_ram(wr_ram),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        ram;
    logic [7:0]  data;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];

  int n_vec = 0;
  int n_err = 0;
  int oe_rises = 0, rdreq_rises = 0, wr_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a request or write.
  logic prev_req = 1'b0;
  logic prev_oe  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rd_req === 1'b1 && !prev_req) begin
      rdreq_rises++;
      if (rd_q.size() == 0) chk("unexpected_rd_req", 32'(rd_addr), 32'hFFFF_FFFF);
      else begin
        e = rd_q.pop_front();
        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
        chk("rd_ram", 32'(rd_ram), 32'(e.ram));
      end
    end
    if (wr_valid === 1'b1) begin
      wr_pulses++;
      if (wr_q.size() == 0) chk("unexpected_wr_valid", 32'(wr_addr), 32'hFFFF_FFFF);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_ram", 32'(wr_ram), 32'(e.ram));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (pad_oe != 8'h00 && !prev_oe) oe_rises++;
    prev_req = rd_req;
    prev_oe  = (pad_oe != 8'h00);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_rdreq(input string tag, input int budget, output int lat);
    lat = 0;
    while (rd_req !== 1'b1 && lat < budget) begin
      tick(1);
      lat++;
    end
    chk({tag, "_rd_req_seen"}, 32'(rd_req), 32'd1);
  endtask

  task automatic do_ack(input logic [7:0] d);
    rd_data = d;
    rd_ack  = 1'b1;
    tick(1);
    rd_ack  = 1'b0;
    rd_data = 8'h00;
  endtask

  task automatic push(ref exp_t q[$], input logic [15:0] a, input logic r, input logic [7:0] d);
    exp_t e;
    e.addr = a; e.ram = r; e.data = d;
    q.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pad_oe"},   32'(pad_oe),   32'd0);
    chk({tag, "_pad_dout"}, 32'(pad_dout), 32'd0);
    chk({tag, "_rd_req"},   32'(rd_req),   32'd0);
    chk({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
    chk({tag, "_rd_ram"},   32'(rd_ram),   32'd0);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
    chk({tag, "_wr_ram"},   32'(wr_ram),   32'd0);
    chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;

    rst_n = 1'b0; gb_addr = 16'h0000; gb_nrd = 1'b1; gb_nwr = 1'b1; gb_ncs = 1'b1;
    pad_din = 8'h00; rd_ack = 1'b0; rd_data = 8'h00;
    tick(3);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick(3);

    // ROM read at 0x0150, ack after 2 cycles
    push(rd_q, 16'h0150, 1'b0, 8'h00);
    gb_addr = 16'h0150; gb_nrd = 1'b0;
    wait_rdreq("rom", 20, lat);
    chk("rom_latency_in_window",
        32'((lat >= SYNC_STAGES + SETTLE) && (lat <= SYNC_STAGES + SETTLE + 2)), 32'd1);
    chk("rom_oe_before_ack", 32'(pad_oe), 32'h00);
    tick(2);
    chk("rom_req_held", 32'(rd_req), 32'd1);
    do_ack(8'h3E);
    chk("rom_oe", 32'(pad_oe), 32'hFF);
    chk("rom_dout", 32'(pad_dout), 32'h3E);
    chk("rom_req_dropped", 32'(rd_req), 32'd0);
    tick(3);
    chk("rom_oe_hold", 32'(pad_oe), 32'hFF);
    gb_nrd = 1'b1;
    tick(1);
    chk("rom_oe_still_driving", 32'(pad_oe), 32'hFF);
    tick(SYNC_STAGES + 1);
    chk("rom_oe_release", 32'(pad_oe), 32'h00);
    tick(4);

    // RAM write at 0xA123 with data 0x5A
    base = wr_pulses;
    push(wr_q, 16'hA123, 1'b1, 8'h5A);
    gb_ncs = 1'b0; gb_addr = 16'hA123; pad_din = 8'h5A; gb_nwr = 1'b0;
    tick(6);
    gb_nwr = 1'b1;
    tick(6);
    gb_ncs = 1'b1; pad_din = 8'h00;
    tick(3);
    chk("ram_write_count", 32'(wr_pulses - base), 32'd1);

    // Back-to-back reads with nRD held low
    base = oe_rises;
    push(rd_q, 16'h0100, 1'b0, 8'h00);
    gb_addr = 16'h0100; gb_nrd = 1'b0;
    wait_rdreq("b2b0", 20, lat);
    do_ack(8'h11);
    chk("b2b0_oe", 32'(pad_oe), 32'hFF);
    chk("b2b0_dout", 32'(pad_dout), 32'h11);
    push(rd_q, 16'h0101, 1'b0, 8'h00);
    gb_addr = 16'h0101;
    tick(SYNC_STAGES + 1);
    chk("b2b_oe_drop", 32'(pad_oe), 32'h00);
    wait_rdreq("b2b1", 20, lat);
    do_ack(8'h22);
    chk("b2b1_oe", 32'(pad_oe), 32'hFF);
    chk("b2b1_dout", 32'(pad_dout), 32'h22);
    gb_nrd = 1'b1;
    tick(6);
    chk("b2b_windows", 32'(oe_rises - base), 32'd2);
    chk("b2b_oe_end", 32'(pad_oe), 32'h00);

    // Abort: address moves before the ack, late ack must be ignored
    base = oe_rises;
    push(rd_q, 16'h0200, 1'b0, 8'h00);
    gb_addr = 16'h0200; gb_nrd = 1'b0;
    wait_rdreq("abort", 20, lat);
    push(rd_q, 16'h0300, 1'b0, 8'h00);
    gb_addr = 16'h0300;
    tick(SYNC_STAGES + 1);
    chk("abort_req_dropped", 32'(rd_req), 32'd0);
    do_ack(8'h99);
    tick(1);
    chk("abort_late_ack_oe", 32'(pad_oe), 32'h00);
    wait_rdreq("abort_requal", 20, lat);
    gb_nrd = 1'b1;
    tick(6);
    chk("abort_req_end", 32'(rd_req), 32'd0);
    chk("abort_no_window", 32'(oe_rises - base), 32'd0);

    // Out-of-range read at 0xC000 with nCS high
    base = rdreq_rises;
    gb_addr = 16'hC000; gb_ncs = 1'b1; gb_nrd = 1'b0;
    tick(15);
    chk("oor_rd_req", 32'(rd_req), 32'd0);
    chk("oor_pad_oe", 32'(pad_oe), 32'h00);
    chk("oor_no_req", 32'(rdreq_rises - base), 32'd0);
    gb_nrd = 1'b1;
    tick(4);

    // Out-of-range write: no wr_valid
    base = wr_pulses;
    gb_addr = 16'hC000; pad_din = 8'hAB; gb_nwr = 1'b0;
    tick(6);
    gb_nwr = 1'b1;
    tick(6);
    chk("oor_no_write", 32'(wr_pulses - base), 32'd0);

    // nRD and nWR low together: write only
    base = oe_rises;
    lat  = rdreq_rises;
    push(wr_q, 16'h2000, 1'b0, 8'h77);
    gb_addr = 16'h2000; pad_din = 8'h77; gb_nrd = 1'b0; gb_nwr = 1'b0;
    tick(6);
    gb_nrd = 1'b1; gb_nwr = 1'b1;
    tick(8);
    chk("both_no_oe", 32'(oe_rises - base), 32'd0);
    chk("both_no_req", 32'(rdreq_rises - lat), 32'd0);
    pad_din = 8'h00;

    // Reset asserted while driving
    push(rd_q, 16'h0150, 1'b0, 8'h00);
    gb_addr = 16'h0150; gb_nrd = 1'b0;
    wait_rdreq("rst", 20, lat);
    do_ack(8'h3E);
    chk("rst_pre_oe", 32'(pad_oe), 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("rst_async_oe", 32'(pad_oe), 32'h00);
    gb_nrd = 1'b1; gb_addr = 16'h0000;
    tick(3);
    rst_n = 1'b1;
    tick(SYNC_STAGES + SETTLE + 4);
    chk_idle_outputs("post_rst");

    chk("rd_scoreboard_empty", 32'(rd_q.size()), 32'd0);
    chk("wr_scoreboard_empty", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
